// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I/RV64I decoder with a DEPTH-entry output buffer
// Optional perf counters: define DECODE_PERF_CNT_EN.
module decode_stage #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [2:0]      out_fmt,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]     perf_decoded,
   output logic [31:0]     perf_illegal
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_SB  = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_UJ  = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [2:0]      fmt;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic [2:0] fmt_w;
   entry_t     dec_d;
   entry_t     mem_q [DEPTH];
   entry_t     head;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic push, pop;

   always_comb begin
      fmt_w = FMT_ILL;
      case (in_instr[6:0])
         7'b0110011: fmt_w = FMT_R;
         7'b0111011: fmt_w = (XLEN == 64) ? FMT_R : FMT_ILL;
         7'b0010011,
         7'b0000011,
         7'b1100111: fmt_w = FMT_I;
         7'b0011011: fmt_w = (XLEN == 64) ? FMT_I : FMT_ILL;
         7'b0100011: fmt_w = FMT_S;
         7'b1100011: fmt_w = FMT_SB;
         7'b0110111,
         7'b0010111: fmt_w = FMT_U;
         7'b1101111: fmt_w = FMT_UJ;
         default:    fmt_w = FMT_ILL;
      endcase
   end

   // Fields a format lacks stay at the zero default.
   always_comb begin
      dec_d         = '0;
      dec_d.pc      = in_pc;
      dec_d.fmt     = fmt_w;
      dec_d.illegal = (fmt_w == FMT_ILL);
      case (fmt_w)
         FMT_R: begin
            dec_d.rd     = in_instr[11:7];
            dec_d.rs1    = in_instr[19:15];
            dec_d.rs2    = in_instr[24:20];
            dec_d.funct3 = in_instr[14:12];
            dec_d.funct7 = in_instr[31:25];
         end
         FMT_I: begin
            dec_d.rd     = in_instr[11:7];
            dec_d.rs1    = in_instr[19:15];
            dec_d.funct3 = in_instr[14:12];
            dec_d.imm    = sext({{20{in_instr[31]}}, in_instr[31:20]});
         end
         FMT_S: begin
            dec_d.rs1    = in_instr[19:15];
            dec_d.rs2    = in_instr[24:20];
            dec_d.funct3 = in_instr[14:12];
            dec_d.imm    = sext({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
         end
         FMT_SB: begin
            dec_d.rs1    = in_instr[19:15];
            dec_d.rs2    = in_instr[24:20];
            dec_d.funct3 = in_instr[14:12];
            dec_d.imm    = sext({{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0});
         end
         FMT_U: begin
            dec_d.rd     = in_instr[11:7];
            dec_d.imm    = sext({in_instr[31:12], 12'b0});
         end
         FMT_UJ: begin
            dec_d.rd     = in_instr[11:7];
            dec_d.imm    = sext({{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0});
         end
         default: ;
      endcase
   end

   assign out_valid = (count_q != '0);
   assign in_ready  = flush | (count_q != FULL_C) | out_ready;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push) mem_q[wr_ptr_q] <= dec_d;
      end
   end

   assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_pc      = head.pc;
   assign out_fmt     = head.fmt;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_rd      = head.rd;
   assign out_funct3  = head.funct3;
   assign out_funct7  = head.funct7;
   assign out_imm     = head.imm;
   assign out_illegal = head.illegal;

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_decoded_q, perf_illegal_q;

   // Survives flush on purpose; only reset clears the counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_decoded_q <= '0;
         perf_illegal_q <= '0;
      end else begin
         if (push && perf_decoded_q != 32'hFFFF_FFFF)
            perf_decoded_q <= perf_decoded_q + 1'b1;
         if (push && dec_d.illegal && perf_illegal_q != 32'hFFFF_FFFF)
            perf_illegal_q <= perf_illegal_q + 1'b1;
      end
   end

   assign perf_decoded = perf_decoded_q;
   assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (XLEN=64, DEPTH=2)
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [2:0]  out_fmt;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [63:0] out_imm;
   logic        out_illegal;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_decoded, perf_illegal;
`endif

   decode_stage #(.XLEN(64), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
      .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
      , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [2:0]  fmt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   perf_dec_exp = 0;
   int   perf_ill_exp = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [63:0] imm);
      exp_t e;
      e.pc = '0; e.fmt = fmt; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      e.f3 = f3; e.f7 = f7; e.imm = imm; e.ill = (fmt == 3'd7);
      return e;
   endfunction

   // Monitor: every real pop is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got pc %0h with empty scoreboard", out_pc);
         end else begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a = {out_pc, out_fmt, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
                 out_imm, out_illegal};
            chk($sformatf("head_pc%0h", e.pc), 160'(a), 160'(e));
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
      bit ok = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (ok) begin
         e.pc = pc;
         q.push_back(e);
         perf_dec_exp++;
         if (e.ill) perf_ill_exp++;
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck 0 for pc %0h", pc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_empty", 160'(q.size()), 160'(0));
   endtask

   exp_t e_addi, e_sw, e_beq, e_lui, e_ill, e_sub, e_jal, e_addiw;

   initial begin
      e_addi  = mk(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      e_sw    = mk(3'd2, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 64'd12);
      e_beq   = mk(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC);
      e_lui   = mk(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0000_0000_1234_5000);
      e_ill   = mk(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
      e_sub   = mk(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0);
      e_jal   = mk(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd8);
      e_addiw = mk(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd1);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      chk("rst_fields", 160'({out_pc, out_fmt, out_imm, out_illegal}), 160'(0));
      rst_n = 1'b1;

      // Latency: accepted at edge N, visible right after it.
      send(32'hFFF1_0093, 64'h1000, e_addi);
      chk("latency_valid", 160'(out_valid), 160'(1));
      chk("latency_fmt", 160'(out_fmt), 160'(1));
      out_ready = 1'b1;
      send(32'h0011_2623, 64'h1004, e_sw);
      send(32'hFE00_0EE3, 64'h1008, e_beq);
      send(32'h1234_52B7, 64'h100C, e_lui);
      send(32'h0000_0000, 64'h1010, e_ill);
      send(32'h4020_81B3, 64'h1014, e_sub);
      send(32'h0080_00EF, 64'h1018, e_jal);
      send(32'h0010_809B, 64'h101C, e_addiw);
      drain();

      // Fill, back-pressure, then same-cycle push+pop on a full buffer.
      out_ready = 1'b0;
      send(32'h4020_81B3, 64'h2000, e_sub);
      send(32'h1234_52B7, 64'h2004, e_lui);
      chk("full_in_ready", 160'(in_ready), 160'(0));
      out_ready = 1'b1;
      send(32'h0080_00EF, 64'h2008, e_jal);
      drain();

      // Flush of a full buffer with a concurrent input that must be dropped.
      out_ready = 1'b0;
      send(32'hFFF1_0093, 64'h3000, e_addi);
      send(32'h0011_2623, 64'h3004, e_sw);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFE00_0EE3; in_pc = 64'h3008;
      @(negedge clk);
      chk("flush_in_ready", 160'(in_ready), 160'(1));
      @(posedge clk);
      q.delete();
      #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 160'(out_valid), 160'(0));
      chk("flush_fields", 160'({out_pc, out_fmt, out_imm}), 160'(0));
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_dropped", 160'(out_valid), 160'(0));

      // Async reset mid-cycle with a full buffer.
      out_ready = 1'b0;
      send(32'hFFF1_0093, 64'h4000, e_addi);
      send(32'h0000_0000, 64'h4004, e_ill);
      #3;
      rst_n = 1'b0;
      #1;
      q.delete();
      perf_dec_exp = 0;
      perf_ill_exp = 0;
      chk("arst_out_valid", 160'(out_valid), 160'(0));
      chk("arst_in_ready", 160'(in_ready), 160'(1));
      chk("arst_fields", 160'({out_pc, out_fmt, out_rd, out_rs1, out_imm, out_illegal}), 160'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      out_ready = 1'b1;
      send(32'h0000_0000, 64'h5000, e_ill);
      send(32'hFE00_0EE3, 64'h5004, e_beq);
      drain();
`ifdef DECODE_PERF_CNT_EN
      chk("perf_decoded", 160'(perf_decoded), 160'(perf_dec_exp));
      chk("perf_illegal", 160'(perf_illegal), 160'(perf_ill_exp));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
